// File: rtl/edge_event_latch.sv
// Probe edge detector with sticky pending vector feeding the channel encoder.
// Synchronises probes, latches masked edges while armed, clears on 1-based ack.
module edge_event_latch #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         arm,
    input  logic [N-1:0] chan_in,
    input  logic [N-1:0] rise_en,
    input  logic [N-1:0] fall_en,
    input  logic         ack,
    input  logic [M:0]   ack_idx,
    output logic [N-1:0] pending,
    output logic         pend_valid,
    output logic         armed,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ARMED  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [1:0]   cnt;
    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] h;
    logic [N-1:0] evt;
    logic [N-1:0] ack_hit;
    logic         cap;
    logic         clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (arm) state_nx = SETTLE;
            SETTLE: begin
                if (!arm)            state_nx = IDLE;
                else if (cnt == 2'd1) state_nx = ARMED;
            end
            ARMED:   if (!arm) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        armed = (state == ARMED);
        cap   = (state == ARMED) && arm;
        clr   = (state_nx == IDLE);
    end

    // Settle counter hides edges that stale history would report on arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       cnt <= 2'd0;
        else if (state == SETTLE && state_nx == SETTLE) cnt <= cnt + 2'd1;
        else                                           cnt <= 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            h  <= '0;
        end else begin
            s1 <= chan_in;
            s2 <= s1;
            h  <= s2;
        end
    end

    always_comb begin
        evt = (s2 & ~h & rise_en) | (~s2 & h & fall_en);
        ack_hit = '0;
        for (int i = 0; i < N; i++) begin
            ack_hit[i] = ack && (ack_idx == (M+1)'(i + 1));
        end
    end

    // A new edge wins over a same-cycle ack of the same channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clr) begin
            pending    <= '0;
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pend_valid <= cap && (|pending);
            if (cap) begin
                pending <= evt | (pending & ~ack_hit);
                if (|(evt & pending & ~ack_hit)) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_latch.sv
// Directed bench for edge_event_latch.
// Expected outputs queue up with each step and are popped at the sample point.
module tb_edge_event_latch;

    localparam int N = 16;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         arm;
    logic [N-1:0] chan_in;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic         ack;
    logic [M:0]   ack_idx;
    logic [N-1:0] pending;
    logic         pend_valid;
    logic         armed;
    logic         overflow;

    typedef struct {
        string        tag;
        logic [N-1:0] pend;
        logic         pv;
        logic         ar;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    edge_event_latch #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .chan_in    (chan_in),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .pending    (pending),
        .pend_valid (pend_valid),
        .armed      (armed),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] p,
                              input logic pv, input logic ar, input logic ov);
        exp_t e;
        e.tag  = tag;
        e.pend = p;
        e.pv   = pv;
        e.ar   = ar;
        e.ov   = ov;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard: empty queue, got pend=%h", pending);
        end else begin
            e = sb.pop_front();
            assert ({pending, pend_valid, armed, overflow} ===
                    {e.pend, e.pv, e.ar, e.ov})
                passed++;
            else
                $error("FAIL %s: got pend=%h pv=%b armed=%b ovf=%b, expected pend=%h pv=%b armed=%b ovf=%b",
                       e.tag, pending, pend_valid, armed, overflow,
                       e.pend, e.pv, e.ar, e.ov);
        end
    endtask

    initial begin
        rst     = 1'b1;
        arm     = 1'b0;
        chan_in = '0;
        rise_en = '0;
        fall_en = '0;
        ack     = 1'b0;
        ack_idx = '0;

        step(3);
        expect_out("reset", 16'h0000, 0, 0, 0); check();
        rst     = 1'b0;
        arm     = 1'b1;
        rise_en = 16'h0008;
        step(1);
        expect_out("arm_a0", 16'h0000, 0, 0, 0); check();
        step(1);
        expect_out("arm_a1", 16'h0000, 0, 0, 0); check();
        step(1);
        expect_out("arm_a2", 16'h0000, 0, 1, 0); check();

        chan_in[3] = 1'b1;
        step(2);
        expect_out("rise_e1", 16'h0000, 0, 1, 0); check();
        step(1);
        expect_out("rise_e2", 16'h0008, 0, 1, 0); check();
        step(1);
        expect_out("rise_e3", 16'h0008, 1, 1, 0); check();
        ack     = 1'b1;
        ack_idx = 5'd4;
        step(1);
        ack = 1'b0;
        expect_out("ack_k", 16'h0000, 1, 1, 0); check();
        step(1);
        expect_out("ack_k1", 16'h0000, 0, 1, 0); check();

        rise_en     = 16'h0000;
        fall_en     = 16'h8001;
        chan_in[0]  = 1'b1;
        chan_in[15] = 1'b1;
        step(3);
        expect_out("mask_rise", 16'h0000, 0, 1, 0); check();
        chan_in[0]  = 1'b0;
        chan_in[15] = 1'b0;
        step(3);
        expect_out("fall_e2", 16'h8001, 0, 1, 0); check();
        ack     = 1'b1;
        ack_idx = 5'd1;
        step(1);
        expect_out("ack_ch0", 16'h8000, 1, 1, 0); check();
        ack_idx = 5'd16;
        step(1);
        ack = 1'b0;
        step(1);
        expect_out("ack_ch15", 16'h0000, 0, 1, 0); check();

        rise_en    = 16'h0020;
        fall_en    = 16'h0020;
        chan_in[5] = 1'b1;
        step(3);
        expect_out("ch5_set", 16'h0020, 0, 1, 0); check();
        chan_in[5] = 1'b0;
        step(2);
        ack     = 1'b1;
        ack_idx = 5'd6;
        step(1);
        ack = 1'b0;
        expect_out("collide", 16'h0020, 1, 1, 0); check();
        chan_in[5] = 1'b1;
        step(3);
        expect_out("ovf_set", 16'h0020, 1, 1, 1); check();
        step(2);
        expect_out("ovf_sticky", 16'h0020, 1, 1, 1); check();

        ack     = 1'b1;
        ack_idx = 5'd6;
        step(1);
        ack      = 1'b0;
        rise_en  = 16'h0101;
        fall_en  = 16'h0000;
        chan_in[0] = 1'b1;
        chan_in[8] = 1'b1;
        step(3);
        expect_out("p0101", 16'h0101, 0, 1, 1); check();
        ack     = 1'b1;
        ack_idx = 5'd0;
        step(1);
        expect_out("ack_idx0", 16'h0101, 1, 1, 1); check();
        ack_idx = 5'd17;
        step(1);
        expect_out("ack_idx17", 16'h0101, 1, 1, 1); check();

        ack_idx = 5'd1;
        step(1);
        ack_idx = 5'd9;
        step(1);
        ack     = 1'b0;
        chan_in = 16'h0000;
        rise_en = 16'hF0F0;
        step(3);
        chan_in = 16'hF0F0;
        step(3);
        expect_out("pF0F0", 16'hF0F0, 0, 1, 1); check();
        arm = 1'b0;
        step(1);
        expect_out("disarm", 16'h0000, 0, 0, 0); check();

        arm = 1'b1;
        step(3);
        expect_out("rearm", 16'h0000, 0, 1, 0); check();
        fall_en = 16'hF0F0;
        chan_in = 16'h0000;
        step(3);
        expect_out("fall_F0F0", 16'hF0F0, 0, 1, 0); check();
        chan_in = 16'hF0F0;
        step(3);
        expect_out("ovf_F0F0", 16'hF0F0, 1, 1, 1); check();
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 16'h0000, 0, 0, 0); check();
        step(1);
        rst = 1'b0;
        expect_out("rst_hold", 16'h0000, 0, 0, 0); check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
